// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives the PC register, runs a single-outstanding imem
// handshake, and hands instructions to decode with stall backpressure and redirects.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned INST_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       pc,
  output logic [63:0]       pc_nxt,
  output logic              pc_en,
  input  logic              stall_f,
  input  logic              br_valid,
  input  logic [63:0]       br_target,
  input  logic              trap_valid,
  input  logic [63:0]       trap_target,
  output logic              ireq_valid,
  output logic [63:0]       ireq_addr,
  input  logic              ireq_ready,
  input  logic              iresp_valid,
  input  logic [INST_W-1:0] iresp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [63:0]       inst_pc,
  output logic              inst_misalign
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDiscard, StOut} state_t;

  state_t      state;
  logic        redirect;
  logic [63:0] rtarget;
  logic        aligned;
  logic        advance;

  always_comb begin
    redirect   = ~reset & (trap_valid | br_valid);
    rtarget    = trap_valid ? trap_target : br_target;
    aligned    = (pc[1:0] == 2'b00);
    advance    = ~reset & (state == StOut) & ~redirect & ~stall_f;
    pc_nxt     = redirect ? rtarget : pc + 64'd4;
    pc_en      = (redirect & (state != StIdle)) | advance;
    ireq_addr  = pc;
    ireq_valid = ~reset & (state == StReq) & aligned & ~redirect;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= StIdle;
      inst_valid    <= 1'b0;
      inst          <= '0;
      inst_pc       <= '0;
      inst_misalign <= 1'b0;
    end else begin
      case (state)
        StIdle: state <= StReq;
        StReq: begin
          if (redirect) begin
            state <= StReq;
          end else if (!aligned) begin
            // Misaligned PC never reaches memory; decode sees a flagged empty slot.
            state         <= StOut;
            inst_valid    <= 1'b1;
            inst          <= '0;
            inst_pc       <= pc;
            inst_misalign <= 1'b1;
          end else if (ireq_ready) begin
            state <= StWait;
          end
        end
        StWait: begin
          if (redirect) begin
            state <= iresp_valid ? StReq : StDiscard;
          end else if (iresp_valid) begin
            state         <= StOut;
            inst_valid    <= 1'b1;
            inst          <= iresp_data;
            inst_pc       <= pc;
            inst_misalign <= 1'b0;
          end
        end
        // Squashed request still owes a response; swallow it before refetching.
        StDiscard: if (iresp_valid) state <= StReq;
        StOut: begin
          if (redirect || !stall_f) begin
            state      <= StReq;
            inst_valid <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // The controller assumes the PC register comes out of reset at RESET_PC.
  always_ff @(posedge clk) begin
    if (!reset && state == StIdle) assert (pc == RESET_PC);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and imem models, directed stimulus, and a
// scoreboard monitor that checks every instruction delivered to decode.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [63:0] pc_nxt;
  logic        pc_en;
  logic        stall_f;
  logic        br_valid;
  logic [63:0] br_target;
  logic        trap_valid;
  logic [63:0] trap_target;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_misalign;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   deliveries = 0;
  int   resp_lat = 1;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC (64'h8000_0000),
    .INST_W   (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .pc_nxt        (pc_nxt),
    .pc_en         (pc_en),
    .stall_f       (stall_f),
    .br_valid      (br_valid),
    .br_target     (br_target),
    .trap_valid    (trap_valid),
    .trap_target   (trap_target),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_ready    (ireq_ready),
    .iresp_valid   (iresp_valid),
    .iresp_data    (iresp_data),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_misalign (inst_misalign)
  );

  // PC register
  always @(posedge clk) begin
    if (reset) pc <= 64'h8000_0000;
    else if (pc_en) pc <= pc_nxt;
  end

  // Instruction memory: word = addr[31:0] - 0x8000_0000 + 0x13, after resp_lat cycles
  logic        pend;
  int          cnt;
  logic [63:0] resp_addr;
  always @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (ireq_valid && ireq_ready) begin
      pend      <= 1'b1;
      cnt       <= resp_lat - 1;
      resp_addr <= ireq_addr;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else cnt <= cnt - 1;
    end
  end
  assign iresp_valid = pend && (cnt == 0);
  assign iresp_data  = resp_addr[31:0] - 32'h8000_0000 + 32'h13;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] i, input logic [63:0] p, input logic m);
    exp_t e;
    e.inst = i;
    e.pc   = p;
    e.mis  = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_inst();
    for (int i = 0; i < 20 && inst_valid !== 1'b1; i++) cyc();
    check("inst_valid_arrives", 64'(inst_valid), 64'd1);
  endtask

  // Scoreboard monitor: pop on each new delivery, check stability while held.
  initial begin
    exp_t        e;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_inst = '0;
    logic [63:0] prev_pc = '0;
    logic        prev_mis = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (inst_valid && !prev_valid) begin
          check("inst_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            deliveries++;
            check("inst", 64'(inst), 64'(e.inst));
            check("inst_pc", inst_pc, e.pc);
            check("inst_misalign", 64'(inst_misalign), 64'(e.mis));
          end
        end else if (inst_valid && prev_valid) begin
          check("hold_inst", 64'(inst), 64'(prev_inst));
          check("hold_inst_pc", inst_pc, prev_pc);
          check("hold_misalign", 64'(inst_misalign), 64'(prev_mis));
        end
        prev_valid = inst_valid;
        prev_inst  = inst;
        prev_pc    = inst_pc;
        prev_mis   = inst_misalign;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; stall_f = 1'b0; br_valid = 1'b0; trap_valid = 1'b0;
    br_target = '0; trap_target = '0; ireq_ready = 1'b1; resp_lat = 1;
    repeat (2) cyc();

    // Reset state; redirect during reset is ignored
    br_valid = 1'b1; br_target = 64'h8000_0040; #1;
    check("rst_pc_en", 64'(pc_en), 64'd0);
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    check("rst_misalign", 64'(inst_misalign), 64'd0);
    cyc(); br_valid = 1'b0; reset = 1'b0; #1;
    check("idle_ireq_valid", 64'(ireq_valid), 64'd0);
    check("idle_pc_en", 64'(pc_en), 64'd0);

    // 1: basic fetch, zero-wait memory
    cyc();
    check("t1_ireq_valid", 64'(ireq_valid), 64'd1);
    check("t1_ireq_addr", ireq_addr, 64'h8000_0000);
    push(32'h13, 64'h8000_0000, 1'b0);
    cyc();
    check("t1_wait_inst_valid", 64'(inst_valid), 64'd0);
    check("t1_wait_ireq_valid", 64'(ireq_valid), 64'd0);
    cyc();
    check("t1_out_inst_valid", 64'(inst_valid), 64'd1);
    check("t1_pc_en", 64'(pc_en), 64'd1);
    check("t1_pc_nxt", pc_nxt, 64'h8000_0004);
    cyc();
    check("t1_next_ireq_valid", 64'(ireq_valid), 64'd1);
    check("t1_next_ireq_addr", ireq_addr, 64'h8000_0004);

    // 2: stall in OUT
    push(32'h17, 64'h8000_0004, 1'b0);
    stall_f = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_inst_valid", 64'(inst_valid), 64'd1);
      check("t2_stall_pc_en", 64'(pc_en), 64'd0);
      check("t2_stall_ireq_valid", 64'(ireq_valid), 64'd0);
      cyc();
    end
    stall_f = 1'b0; #1;
    check("t2_adv_pc_en", 64'(pc_en), 64'd1);
    check("t2_adv_pc_nxt", pc_nxt, 64'h8000_0008);
    cyc();
    check("t2_next_ireq_addr", ireq_addr, 64'h8000_0008);
    resp_lat = 3;

    // 3: branch in WAIT, response arrives in DISCARD and is dropped
    cyc();
    br_valid = 1'b1; br_target = 64'h8000_0100; #1;
    check("t3_pc_en", 64'(pc_en), 64'd1);
    check("t3_pc_nxt", pc_nxt, 64'h8000_0100);
    check("t3_ireq_valid", 64'(ireq_valid), 64'd0);
    cyc(); br_valid = 1'b0; #1;
    check("t3_disc_ireq_valid", 64'(ireq_valid), 64'd0);
    check("t3_disc_inst_valid", 64'(inst_valid), 64'd0);
    cyc();
    check("t3_disc_resp_ireq_valid", 64'(ireq_valid), 64'd0);
    check("t3_disc_resp_inst_valid", 64'(inst_valid), 64'd0);
    cyc();
    check("t3_refetch_ireq_valid", 64'(ireq_valid), 64'd1);
    check("t3_refetch_ireq_addr", ireq_addr, 64'h8000_0100);
    resp_lat = 1;
    push(32'h113, 64'h8000_0100, 1'b0);
    wait_inst();
    check("t3_adv_pc_nxt", pc_nxt, 64'h8000_0104);

    // 4: trap beats branch in the same cycle
    cyc();
    trap_valid = 1'b1; trap_target = 64'h8000_1000;
    br_valid = 1'b1; br_target = 64'h8000_0200; #1;
    check("t4_pc_nxt", pc_nxt, 64'h8000_1000);
    check("t4_pc_en", 64'(pc_en), 64'd1);
    check("t4_ireq_valid", 64'(ireq_valid), 64'd0);
    cyc(); trap_valid = 1'b0; br_valid = 1'b0; #1;
    check("t4_ireq_valid_after", 64'(ireq_valid), 64'd1);
    check("t4_ireq_addr", ireq_addr, 64'h8000_1000);
    push(32'h1013, 64'h8000_1000, 1'b0);
    wait_inst();

    // 5: redirect from OUT to a misaligned target
    br_valid = 1'b1; br_target = 64'h8000_0102; #1;
    check("t5_pc_nxt", pc_nxt, 64'h8000_0102);
    cyc(); br_valid = 1'b0; #1;
    check("t5_ireq_valid", 64'(ireq_valid), 64'd0);
    check("t5_ireq_addr", ireq_addr, 64'h8000_0102);
    push(32'h0, 64'h8000_0102, 1'b1);
    cyc();
    check("t5_inst_valid", 64'(inst_valid), 64'd1);
    check("t5_out_ireq_valid", 64'(ireq_valid), 64'd0);
    br_valid = 1'b1; br_target = 64'h8000_0200; #1;
    check("t5_escape_pc_nxt", pc_nxt, 64'h8000_0200);
    cyc(); br_valid = 1'b0; #1;
    check("t5_escape_ireq_valid", 64'(ireq_valid), 64'd1);
    resp_lat = 3;

    // 6: reset while waiting for a response
    cyc();
    reset = 1'b1; #1;
    check("t6_rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("t6_rst_pc_en", 64'(pc_en), 64'd0);
    cyc();
    check("t6_idle_inst_valid", 64'(inst_valid), 64'd0);
    check("t6_idle_inst", 64'(inst), 64'd0);
    check("t6_idle_inst_pc", inst_pc, 64'd0);
    check("t6_idle_misalign", 64'(inst_misalign), 64'd0);
    reset = 1'b0; resp_lat = 1; #1;
    check("t6_idle_ireq_valid", 64'(ireq_valid), 64'd0);
    cyc();
    check("t6_ireq_valid", 64'(ireq_valid), 64'd1);
    check("t6_ireq_addr", ireq_addr, 64'h8000_0000);
    push(32'h13, 64'h8000_0000, 1'b0);
    wait_inst();
    repeat (3) cyc();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("deliveries", 64'(deliveries), 64'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
